// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: FSM state enum, requester index type, default memory depth.
package mem_arb_pkg;

    // Default number of data-memory words.
    localparam int unsigned MEM_ARB_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Requester index: 0 = pipeline MEM stage, 1 = loader/DMA.
    typedef logic port_idx_t;

endpackage

// File: rtl/arb_pick.sv
// Tie resolver between the two requesters of mem_arbiter.
// Latency: purely combinational.
// Backpressure: none; the loser simply keeps its request asserted.
//
// Ports: req0/req1 requests, last_grant previously served port, winner chosen port.
// Macro MEM_ARB_RR_EN: defined -> ties alternate (round-robin),
//                      undefined -> ties always go to port 0.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic      req0,
    input  logic      req1,
    input  port_idx_t last_grant,
    output port_idx_t winner
);

    always_comb begin
        // With no request the choice is irrelevant; keep the previous grant.
        winner = last_grant;
`ifdef MEM_ARB_RR_EN
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req0) begin
            winner = 1'b0;
        end else if (req1) begin
            winner = 1'b1;
        end
`else
        if (req0) begin
            winner = 1'b0;
        end else if (req1) begin
            winner = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Latency: fixed 3 cycles, request sampled in IDLE -> ack pulse two cycles later.
// Backpressure: requesters hold req/we/addr/wdata until their ack; requests seen
//               outside IDLE simply wait.
//
// Ports: clk, reset (sync, active high); req/we/addr/wdata per requester in,
//        ack/err/rdata per requester out; data_address/data/MemRead/MemWrite to
//        the memory, MemOut from it.
// Macro MEM_ARB_RR_EN: round-robin tie break (otherwise port 0 always wins ties).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_ARB_DEPTH
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] data_address,
    output logic [31:0] data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemOut
);

    localparam logic [31:0] LP_DEPTH = 32'(DEPTH);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    port_idx_t   r_win;
    port_idx_t   w_pick;
    port_idx_t   w_last;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        w_in_range;
    logic        w_any_req;
    logic [31:0] w_rd_val;

    assign w_any_req  = req0 | req1;
    assign w_in_range = (r_addr < LP_DEPTH);
    // Writes and out-of-range accesses return zero.
    assign w_rd_val   = (!r_we && w_in_range) ? MemOut : 32'h0;

`ifdef MEM_ARB_RR_EN
    port_idx_t r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (r_state == IDLE && w_any_req) begin
            r_last <= w_pick;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = 1'b0;
`endif

    arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (w_last),
        .winner     (w_pick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and memory/response strobes. Every strobe is gated by reset
    // so an access interrupted by reset never touches memory or acks.
    always_comb begin
        w_next_state = r_state;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        err0         = 1'b0;
        err1         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                w_next_state = RESP;
                MemRead      = ~r_we & w_in_range & ~reset;
                MemWrite     =  r_we & w_in_range & ~reset;
            end
            RESP: begin
                w_next_state = IDLE;
                ack0         = ~reset & (r_win == 1'b0);
                ack1         = ~reset & (r_win == 1'b1);
                err0         = ack0 & ~w_in_range;
                err1         = ack1 & ~w_in_range;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request capture and per-port read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rdata0 <= 32'h0;
            r_rdata1 <= 32'h0;
        end else begin
            if (r_state == IDLE && w_any_req) begin
                r_win   <= w_pick;
                r_we    <= w_pick ? we1    : we0;
                r_addr  <= w_pick ? addr1  : addr0;
                r_wdata <= w_pick ? wdata1 : wdata0;
            end
            if (r_state == ACCESS) begin
                if (r_win) begin
                    r_rdata1 <= w_rd_val;
                end else begin
                    r_rdata0 <= w_rd_val;
                end
            end
        end
    end

    assign data_address = r_addr;
    assign data         = r_wdata;
    assign rdata0       = r_rdata0;
    assign rdata1       = r_rdata1;

endmodule
